// File: rtl/generic_memory_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_PORTS requesters.
// Define GENERIC_MEMORY_ARBITER_CLEAR_EN to zero-fill the memory after reset before granting.
module generic_memory_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                            CLK,
  input  logic                            RSTN,
  input  logic [NUM_PORTS-1:0]            req_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS-1:0]            wen_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_PORTS*BE_WIDTH-1:0]   be_i,
  output logic [NUM_PORTS-1:0]            r_valid_o,
  output logic [DATA_WIDTH-1:0]           r_rdata_o,
  output logic                            init_done_o,
  output logic                            mem_initn_o,
  output logic                            mem_cen_o,
  output logic [ADDR_WIDTH-1:0]           mem_a_o,
  output logic                            mem_wen_o,
  output logic [DATA_WIDTH-1:0]           mem_d_o,
  output logic [BE_WIDTH-1:0]             mem_ben_o,
  input  logic [DATA_WIDTH-1:0]           mem_q_i
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

`ifdef GENERIC_MEMORY_ARBITER_CLEAR_EN
  localparam state_e RESET_STATE = ST_CLEAR;
  logic [ADDR_WIDTH-1:0] clr_q, clr_d;
`else
  localparam state_e RESET_STATE = ST_RUN;
`endif

  state_e               state_q, state_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic                 init_done_q, init_done_d;
  logic [NUM_PORTS-1:0] resp_q, resp_d;

  logic [PW-1:0]        win_s;
  logic                 win_vld_s;
  logic [PW-1:0]        cand_s;
  logic [PW-1:0]        sel_s;
  logic                 active_s;
  logic [NUM_PORTS-1:0] gnt_s;

  // Round-robin search from rr_q; iterating downward lets the closest requester win.
  always_comb begin
    win_s     = rr_q;
    win_vld_s = 1'b0;
    cand_s    = rr_q;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand_s = PW'((32'(rr_q) + 32'(k)) % NUM_PORTS);
      if (req_i[cand_s]) begin
        win_s     = cand_s;
        win_vld_s = 1'b1;
      end else begin
        win_s     = win_s;
        win_vld_s = win_vld_s;
      end
    end
  end

  // Grant is only legal once initialisation is complete and reset is released.
  always_comb begin
    active_s = RSTN && init_done_q && (state_q == ST_RUN);
    gnt_s    = '0;
    if (active_s && win_vld_s) begin
      gnt_s[win_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  // Memory strobes: granted port's request, clear sweep, or idle with rr_q slice on the bus.
  always_comb begin
    sel_s     = (|gnt_s) ? win_s : rr_q;
    mem_cen_o = ~(|gnt_s);
    mem_a_o   = addr_i[sel_s*ADDR_WIDTH +: ADDR_WIDTH];
    mem_wen_o = wen_i[sel_s];
    mem_d_o   = wdata_i[sel_s*DATA_WIDTH +: DATA_WIDTH];
    mem_ben_o = ~be_i[sel_s*BE_WIDTH +: BE_WIDTH];
`ifdef GENERIC_MEMORY_ARBITER_CLEAR_EN
    if (RSTN && (state_q == ST_CLEAR)) begin
      mem_cen_o = 1'b0;
      mem_wen_o = 1'b0;
      mem_ben_o = '0;
      mem_d_o   = '0;
      mem_a_o   = clr_q;
    end else begin
      mem_cen_o = mem_cen_o;
    end
`endif
  end

  // Next-state, round-robin pointer and response tracking.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    init_done_d = init_done_q;
    resp_d      = gnt_s;
`ifdef GENERIC_MEMORY_ARBITER_CLEAR_EN
    clr_d       = clr_q;
`endif
    case (state_q)
      ST_CLEAR: begin
`ifdef GENERIC_MEMORY_ARBITER_CLEAR_EN
        clr_d = clr_q + ADDR_WIDTH'(1);
        if (clr_q == {ADDR_WIDTH{1'b1}}) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          state_d     = ST_CLEAR;
          init_done_d = 1'b0;
        end
`else
        state_d     = ST_RUN;
        init_done_d = 1'b1;
`endif
      end
      ST_RUN: begin
        init_done_d = 1'b1;
        if (|gnt_s) begin
          rr_d = (win_s == PW'(NUM_PORTS - 1)) ? '0 : win_s + PW'(1);
        end else begin
          rr_d = rr_q;
        end
      end
      default: begin
        state_d     = RESET_STATE;
        init_done_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q     <= RESET_STATE;
      rr_q        <= '0;
      init_done_q <= 1'b0;
      resp_q      <= '0;
`ifdef GENERIC_MEMORY_ARBITER_CLEAR_EN
      clr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      init_done_q <= init_done_d;
      resp_q      <= resp_d;
`ifdef GENERIC_MEMORY_ARBITER_CLEAR_EN
      clr_q       <= clr_d;
`endif
    end
  end

  assign gnt_o       = gnt_s;
  assign r_valid_o   = resp_q;
  assign r_rdata_o   = mem_q_i;
  assign init_done_o = init_done_q;
  assign mem_initn_o = RSTN;

endmodule

// File: doc/generic_memory_arbiter.md
Name: generic_memory_arbiter

Overview:
- Shares one single-port generic_memory_data instance between NUM_PORTS requesters using a request/grant protocol.
- Arbitrates round-robin, translates each winning request into memory strobes (CEN/WEN/BEN, all active-low), and routes the read data back to the granted port one cycle later.
- Sits between cluster-side masters and the memory macro.
- Optionally zero-fills the memory after reset before granting any request.

Parameters:
- NUM_PORTS, 4, number of requesters (>=2).
- ADDR_WIDTH, 12, memory word-address width.
- DATA_WIDTH, 32, data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RSTN  in  1  reset; synchronous, active-low.
- req_i  in  NUM_PORTS  per-port request.
- gnt_o  out  NUM_PORTS  per-port grant, one-hot or zero.
- addr_i  in  NUM_PORTS*ADDR_WIDTH  per-port word address; port p occupies slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- wen_i  in  NUM_PORTS  per-port write enable, active-low (0 = write, 1 = read).
- wdata_i  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- be_i  in  NUM_PORTS*BE_WIDTH  per-port byte enable, active-high.
- r_valid_o  out  NUM_PORTS  per-port response pulse.
- r_rdata_o  out  DATA_WIDTH  shared read-data bus; valid only when some r_valid_o bit is 1.
- init_done_o  out  1  high once the arbiter accepts requests.
- mem_initn_o  out  1  to memory INITN.
- mem_cen_o  out  1  to memory CEN.
- mem_a_o  out  ADDR_WIDTH  to memory A.
- mem_wen_o  out  1  to memory WEN.
- mem_d_o  out  DATA_WIDTH  to memory D.
- mem_ben_o  out  BE_WIDTH  to memory BEN (active-low).
- mem_q_i  in  DATA_WIDTH  from memory Q.

Behaviour:
- Reset is synchronous, active-low. While RSTN=0 and on the first edge after it:
  - gnt_o=0, r_valid_o=0, init_done_o=0, mem_initn_o=0, mem_cen_o=1.
  - Round-robin pointer rr_q=0; response-port register resp_q cleared.
- State machine: two states, CLEAR and RUN.
  - Reset enters RUN, or CLEAR when the Optional Feature is compiled in.
  - mem_initn_o=1 whenever RSTN=1.
- RUN arbitration (combinational, same cycle as req_i):
  - Search ports starting at rr_q, wrapping modulo NUM_PORTS; the first port with req_i=1 gets gnt_o=1.
  - gnt_o=0 when init_done_o=0 or RSTN=0.
- On a grant to port w:
  - mem_cen_o=0, mem_a_o=addr[w], mem_wen_o=wen[w], mem_d_o=wdata[w], mem_ben_o=~be[w].
  - rr_q <= (w+1) mod NUM_PORTS; with NUM_PORTS-1 the pointer wraps to 0.
- No grant: mem_cen_o=1, rr_q holds, and the other memory outputs hold don't-care values (implementation drives the port rr_q slice).
- Response, fixed latency 1 cycle after the grant edge:
  - r_valid_o[w]=1 for exactly one cycle, for both reads and writes.
  - For reads, r_rdata_o=mem_q_i in that cycle. For writes, r_rdata_o is don't-care.
- Throughput: one grant per cycle. Back-to-back grants and responses are allowed; a response and a new grant may coincide in the same cycle.
- A requester must hold req_i, addr_i, wen_i, wdata_i and be_i stable until granted.
- Starvation bound: a continuously requesting port is granted within NUM_PORTS cycles.
- be_i=0 on a write: memory access still issued with mem_ben_o all ones (no bytes change), and r_valid_o is still returned.
- Reset asserted mid-operation: any pending response is dropped and r_valid_o=0 on the next edge.

Optional Feature:
- Macro: GENERIC_MEMORY_ARBITER_CLEAR_EN.
- Defined:
  - After reset, FSM is in CLEAR with counter clr_q=0.
  - Each cycle drives mem_cen_o=0, mem_wen_o=0, mem_ben_o=0, mem_d_o=0, mem_a_o=clr_q, then increments clr_q.
  - When clr_q=2^ADDR_WIDTH-1 is written, next state is RUN and init_done_o becomes 1 on that same edge.
  - Total: 2^ADDR_WIDTH write cycles; gnt_o=0 and no responses throughout.
- Undefined: FSM enters RUN directly and init_done_o rises on the first edge with RSTN=1.

Test Plan:
- Single port: port 0 writes 0xDEADBEEF to addr 0x005 with be=0xF, then reads 0x005 -> gnt same cycle each time; read r_valid_o[0]=1 one cycle later with r_rdata_o=0xDEADBEEF.
- Byte mask: write 0x11223344 to addr 0x010, then write 0xAABBCCDD with be=0x2 -> read returns 0x1122CC44.
- Round-robin: all 4 ports request continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each port gets exactly 2 responses.
- Wrap/priority: rr_q=3, ports 1 and 3 requesting -> port 3 granted, then port 1 next cycle; rr_q becomes 0, then 2.
- Clear (macro on, ADDR_WIDTH=4): memory preloaded with nonzero data, reset released -> gnt_o=0 for 16 cycles, init_done_o=1 afterwards, reads of addr 0..15 return 0.
- Reset mid-operation: read granted, RSTN=0 on the next edge -> no r_valid_o; rr_q=0 after reset.
